// File: rtl/multi_ch_watchdog.sv
// N-channel heartbeat watchdog: per-channel timeout, early warning, revive reset pulse
// and lock-in fault after repeated consecutive revives.
module multi_ch_watchdog #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter int unsigned WARN_CYCLES    = 5_000_000,
   parameter int unsigned RESET_CYCLES   = 10_000,
   parameter int unsigned MAX_REVIVE     = 3,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned REV_W          = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       i_en,
   input  logic [NUM_CH-1:0]       i_kick,
   input  logic [NUM_CH-1:0]       i_clear,
   output logic [NUM_CH-1:0]       o_sys_reset,
   output logic [NUM_CH-1:0]       o_warn,
   output logic [NUM_CH-1:0]       o_fault,
   output logic                    o_any_reset,
   output logic [NUM_CH*REV_W-1:0] o_revive_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_WARN,
      ST_REVIVE,
      ST_LOCKED
   } state_t;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] WARN_TH  = CNT_W'(TIMEOUT_CYCLES - WARN_CYCLES);
   localparam logic [REV_W-1:0] REV_MAX  = REV_W'(MAX_REVIVE);
   localparam logic [REV_W-1:0] REV_SAT  = {REV_W{1'b1}};
   localparam bit               WARN_EN  = (WARN_CYCLES != 0);
   localparam bit               LOCK_EN  = (MAX_REVIVE != 0);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
      logic [REV_W-1:0] rev_q, rev_d;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rev_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rev_q   <= rev_d;
         end
      end

      // Priority: disable (unless locked) > clear (locked) > kick > timeout
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         rev_d   = rev_q;
         cnt_inc = cnt_q + CNT_W'(1);
         if (!i_en[k] && (state_q != ST_LOCKED)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  cnt_d = '0;
                  if (i_clear[k]) rev_d = '0;
                  if (i_en[k]) state_d = ST_ARMED;
               end
               ST_ARMED, ST_WARN: begin
                  if (i_kick[k]) begin
                     state_d = ST_ARMED;
                     cnt_d   = '0;
                     rev_d   = '0;
                  end else if (cnt_q == TMO_LAST) begin
                     state_d = ST_REVIVE;
                     cnt_d   = '0;
                     if (rev_q != REV_SAT) rev_d = rev_q + REV_W'(1);
                  end else begin
                     cnt_d   = cnt_inc;
                     state_d = (WARN_EN && (cnt_inc >= WARN_TH)) ? ST_WARN : ST_ARMED;
                  end
               end
               ST_REVIVE: begin
                  if (cnt_q == RST_LAST) begin
                     cnt_d   = '0;
                     state_d = (LOCK_EN && (rev_q == REV_MAX)) ? ST_LOCKED : ST_ARMED;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
               ST_LOCKED: begin
                  cnt_d = '0;
                  if (i_clear[k]) begin
                     state_d = ST_IDLE;
                     rev_d   = '0;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end

      assign o_sys_reset[k] = (state_q == ST_REVIVE) || (state_q == ST_LOCKED);
      assign o_warn[k]      = (state_q == ST_WARN);
      assign o_fault[k]     = (state_q == ST_LOCKED);
      assign o_revive_cnt[k*REV_W +: REV_W] = rev_q;
   end

   assign o_any_reset = |o_sys_reset;

endmodule
